// File: rtl/video_src_sched_if.sv
// Signal bundle between the capture sequencer and its neighbours:
// the user key, both vsync sources, the OV2640 controller and the frame-buffer mux.
interface video_src_sched_if;
  logic       key;
  logic       cam_vsync;
  logic       tp_vs;
  logic       config_finished;
  logic       src_sel;
  logic       wr_halt;
  logic       resend;
  logic [9:0] zoom;
  logic       busy;
  logic       drop;
  logic       cfg_err;

  // Sequencer side
  modport slave (
    input  key, cam_vsync, tp_vs, config_finished,
    output src_sel, wr_halt, resend, zoom, busy, drop, cfg_err
  );

  // Environment side (key, sensors, controller)
  modport master (
    output key, cam_vsync, tp_vs, config_finished,
    input  src_sel, wr_halt, resend, zoom, busy, drop, cfg_err
  );
endinterface

// File: rtl/video_src_sched.sv
// Capture front-end sequencer: debounces the user key, decodes short/long
// presses, steps the OV2640 zoom with a sensor resend on short presses, and
// switches the frame-buffer source on frame boundaries on long presses while
// halting frame-buffer writes so no torn frame reaches memory.
//
// Request/done pair towards the OV2640 controller: resend is a level held for
// exactly RESEND_CYCLES cycles (long enough for the slower config clock to
// sample it); completion is a rising edge of config_finished, seen only while
// waiting for it and bounded by CFG_TIMEOUT_MS.
module video_src_sched #(
  parameter int         CLK_HZ         = 27_000_000,
  parameter int         DEBOUNCE_MS    = 20,
  parameter int         LONG_MS        = 500,
  parameter int         RESEND_CYCLES  = 16,
  parameter int         CFG_TIMEOUT_MS = 200,
  parameter int         VS_TIMEOUT_MS  = 100,
  // Power-on zoom value; 0 in normal use
  parameter logic [9:0] ZOOM_INIT      = 10'd0
) (
  input  logic                    I_clk,
  input  logic                    sys_resetn,
  video_src_sched_if.slave        sched_if,
  output logic [2:0]              dbg_state_o
);

  localparam int MS        = CLK_HZ / 1000;
  localparam int DB_CYC    = DEBOUNCE_MS * MS;
  localparam int LONG_CYC  = LONG_MS * MS;
  localparam int CFG_CYC   = CFG_TIMEOUT_MS * MS;
  localparam int VS_CYC    = VS_TIMEOUT_MS * MS;
  localparam int TMR_MAX_A = (CFG_CYC > VS_CYC) ? CFG_CYC : VS_CYC;
  localparam int TMR_MAX_B = (TMR_MAX_A > LONG_CYC) ? TMR_MAX_A : LONG_CYC;
  localparam int TMR_MAX   = (TMR_MAX_B > RESEND_CYCLES) ? TMR_MAX_B : RESEND_CYCLES;
  localparam int TMR_W     = $clog2(TMR_MAX + 1);
  localparam int DB_W      = $clog2(DB_CYC + 1);
  localparam int DUR_W     = $clog2(LONG_CYC + 1);

  localparam logic [TMR_W-1:0] RESEND_LAST = TMR_W'(RESEND_CYCLES - 1);
  localparam logic [TMR_W-1:0] CFG_LAST    = TMR_W'(CFG_CYC - 1);
  localparam logic [TMR_W-1:0] VS_LAST     = TMR_W'(VS_CYC - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(DB_CYC - 1);
  localparam logic [DUR_W-1:0] LONG_SAT    = DUR_W'(LONG_CYC);

  localparam logic [2:0] ST_BOOT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_SW_OLD    = 3'd2;
  localparam logic [2:0] ST_SW_NEW    = 3'd3;
  localparam logic [2:0] ST_CFG_PULSE = 3'd4;
  localparam logic [2:0] ST_CFG_WAIT  = 3'd5;

  // Synchronisers and edge-detect history
  logic key_s1_q, key_s2_q;
  logic cam_s1_q, cam_s2_q, cam_prev_q;
  logic cfg_s1_q, cfg_s2_q, cfg_prev_q;
  logic tp_prev_q;

  // Debounce and press decode
  logic             stable_q;
  logic [DB_W-1:0]  db_cnt_q;
  logic [DUR_W-1:0] dur_q;
  logic             short_ev_q, long_ev_q;

  // Sequencer state
  logic [2:0]       state_q, state_d;
  logic [TMR_W-1:0] tmr_q;
  logic [9:0]       zoom_q, zoom_d;
  logic             src_sel_q, src_sel_d;
  logic             wr_halt_q, wr_halt_d;
  logic             cfg_err_q, cfg_err_d;
  logic             drop_q, drop_d;
  logic             resend_q, busy_q;

  logic pressed;
  logic cam_fall, tp_fall, vs_fall, cfg_rise;
  logic wait_armed;

  assign pressed  = ~key_s2_q;
  assign cam_fall = cam_prev_q & ~cam_s2_q;
  assign tp_fall  = tp_prev_q & ~sched_if.tp_vs;
  // The active vsync follows the current source selection
  assign vs_fall  = src_sel_q ? tp_fall : cam_fall;
  assign cfg_rise = cfg_s2_q & ~cfg_prev_q;
  // The timer reads zero only on the entry cycle; edges there are ignored
  assign wait_armed = (tmr_q != '0);

  // Two-flop synchronisers plus one history register for edge detection
  always_ff @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      key_s1_q   <= 1'b1;
      key_s2_q   <= 1'b1;
      cam_s1_q   <= 1'b0;
      cam_s2_q   <= 1'b0;
      cam_prev_q <= 1'b0;
      cfg_s1_q   <= 1'b0;
      cfg_s2_q   <= 1'b0;
      cfg_prev_q <= 1'b0;
      tp_prev_q  <= 1'b0;
    end else begin
      key_s1_q   <= sched_if.key;
      key_s2_q   <= key_s1_q;
      cam_s1_q   <= sched_if.cam_vsync;
      cam_s2_q   <= cam_s1_q;
      cam_prev_q <= cam_s2_q;
      cfg_s1_q   <= sched_if.config_finished;
      cfg_s2_q   <= cfg_s1_q;
      cfg_prev_q <= cfg_s2_q;
      tp_prev_q  <= sched_if.tp_vs;
    end
  end

  // Debounce the key, time the press and emit one-cycle short/long events on release
  always_ff @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      stable_q   <= 1'b0;
      db_cnt_q   <= '0;
      dur_q      <= '0;
      short_ev_q <= 1'b0;
      long_ev_q  <= 1'b0;
    end else begin
      short_ev_q <= 1'b0;
      long_ev_q  <= 1'b0;
      if (stable_q && dur_q != LONG_SAT) begin
        dur_q <= dur_q + 1'b1;
      end
      if (pressed != stable_q) begin
        if (db_cnt_q == DB_LAST) begin
          db_cnt_q <= '0;
          stable_q <= pressed;
          if (pressed) begin
            dur_q <= '0;
          end else if (dur_q == LONG_SAT) begin
            long_ev_q <= 1'b1;
          end else begin
            short_ev_q <= 1'b1;
          end
        end else begin
          db_cnt_q <= db_cnt_q + 1'b1;
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  // Next-state and output decisions for the sequencer
  always_comb begin
    state_d   = state_q;
    zoom_d    = zoom_q;
    src_sel_d = src_sel_q;
    wr_halt_d = wr_halt_q;
    cfg_err_d = cfg_err_q;
    drop_d    = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_CFG_PULSE;
      end
      ST_IDLE: begin
        if (short_ev_q) begin
          zoom_d  = zoom_q + 10'd1;
          state_d = ST_CFG_PULSE;
        end else if (long_ev_q) begin
          wr_halt_d = 1'b1;
          state_d   = ST_SW_OLD;
        end
      end
      ST_SW_OLD: begin
        if ((vs_fall && wait_armed) || tmr_q == VS_LAST) begin
          src_sel_d = ~src_sel_q;
          state_d   = ST_SW_NEW;
        end
      end
      ST_SW_NEW: begin
        if ((vs_fall && wait_armed) || tmr_q == VS_LAST) begin
          wr_halt_d = 1'b0;
          state_d   = src_sel_q ? ST_IDLE : ST_CFG_PULSE;
        end
      end
      ST_CFG_PULSE: begin
        if (tmr_q == RESEND_LAST) begin
          state_d = ST_CFG_WAIT;
        end
      end
      ST_CFG_WAIT: begin
        if (cfg_rise && wait_armed) begin
          state_d = ST_IDLE;
        end else if (tmr_q == CFG_LAST) begin
          cfg_err_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_BOOT;
      end
    endcase
    // Key events arriving outside IDLE are discarded and reported
    if ((short_ev_q || long_ev_q) && state_q != ST_IDLE) begin
      drop_d = 1'b1;
    end
  end

  // State, shared timer (restarts on every state change) and registered outputs
  always_ff @(posedge I_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      state_q   <= ST_BOOT;
      tmr_q     <= '0;
      zoom_q    <= ZOOM_INIT;
      src_sel_q <= 1'b0;
      wr_halt_q <= 1'b0;
      cfg_err_q <= 1'b0;
      drop_q    <= 1'b0;
      resend_q  <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      zoom_q    <= zoom_d;
      src_sel_q <= src_sel_d;
      wr_halt_q <= wr_halt_d;
      cfg_err_q <= cfg_err_d;
      drop_q    <= drop_d;
      resend_q  <= (state_d == ST_CFG_PULSE);
      busy_q    <= (state_d != ST_IDLE);
      if (state_d != state_q) begin
        tmr_q <= '0;
      end else if (tmr_q != '1) begin
        tmr_q <= tmr_q + 1'b1;
      end
    end
  end

  assign sched_if.src_sel = src_sel_q;
  assign sched_if.wr_halt = wr_halt_q;
  assign sched_if.resend  = resend_q;
  assign sched_if.zoom    = zoom_q;
  assign sched_if.busy    = busy_q;
  assign sched_if.drop    = drop_q;
  assign sched_if.cfg_err = cfg_err_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_video_src_sched.sv
// Directed bench for video_src_sched with a 1 ms = 10 cycle time base.
// A second instance powers up with zoom 1023 to reach the wrap case quickly.
module tb_video_src_sched;

  localparam int CLK_HZ         = 10_000;
  localparam int DEBOUNCE_MS    = 2;
  localparam int LONG_MS        = 10;
  localparam int VS_TIMEOUT_MS  = 5;
  localparam int CFG_TIMEOUT_MS = 8;

  localparam logic [2:0] ST_BOOT      = 3'd0;
  localparam logic [2:0] ST_IDLE      = 3'd1;
  localparam logic [2:0] ST_SW_OLD    = 3'd2;
  localparam logic [2:0] ST_SW_NEW    = 3'd3;
  localparam logic [2:0] ST_CFG_PULSE = 3'd4;
  localparam logic [2:0] ST_CFG_WAIT  = 3'd5;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn   = 1'b0;
  logic rstn_w = 1'b0;

  video_src_sched_if vif ();
  video_src_sched_if wif ();
  logic [2:0] dbg_state, dbg_state_w;

  video_src_sched #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS),
    .RESEND_CYCLES(16), .CFG_TIMEOUT_MS(CFG_TIMEOUT_MS), .VS_TIMEOUT_MS(VS_TIMEOUT_MS)
  ) dut (
    .I_clk(clk), .sys_resetn(rstn), .sched_if(vif), .dbg_state_o(dbg_state)
  );

  video_src_sched #(
    .CLK_HZ(CLK_HZ), .DEBOUNCE_MS(DEBOUNCE_MS), .LONG_MS(LONG_MS),
    .RESEND_CYCLES(16), .CFG_TIMEOUT_MS(CFG_TIMEOUT_MS), .VS_TIMEOUT_MS(VS_TIMEOUT_MS),
    .ZOOM_INIT(10'd1023)
  ) dut_w (
    .I_clk(clk), .sys_resetn(rstn_w), .sched_if(wif), .dbg_state_o(dbg_state_w)
  );

  int checks = 0;
  int errors = 0;

  // Expected zoom sequence of the main instance
  logic [9:0] exp_q[$];

  // Event monitors sampled on the falling edge
  int   resend_rises = 0;
  int   drop_cnt     = 0;
  int   drop_cnt_w   = 0;
  logic resend_prev  = 1'b0;
  always @(negedge clk) begin
    if (vif.resend === 1'b1 && resend_prev !== 1'b1) resend_rises++;
    resend_prev = vif.resend;
    if (vif.drop === 1'b1) drop_cnt++;
    if (wif.drop === 1'b1) drop_cnt_w++;
  end

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_key(input bit on_w, input logic v);
    if (on_w) wif.key = v;
    else      vif.key = v;
  endtask

  task automatic press(input bit on_w, input int hold);
    set_key(on_w, 1'b0);
    tick(hold);
    set_key(on_w, 1'b1);
  endtask

  task automatic pulse_cfg(input bit on_w);
    if (on_w) wif.config_finished = 1'b1;
    else      vif.config_finished = 1'b1;
    tick(6);
    if (on_w) wif.config_finished = 1'b0;
    else      vif.config_finished = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    int hi;
    int n;
    rstn = 1'b0;
    tick(3);
    checks++;
    if ({vif.src_sel, vif.wr_halt, vif.resend, vif.busy, vif.drop, vif.cfg_err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {vif.src_sel, vif.wr_halt, vif.resend, vif.busy, vif.drop, vif.cfg_err});
    end
    checks++;
    if (vif.zoom !== 10'd0) begin
      errors++;
      $display("FAIL reset_zoom: got %0d expected 0", vif.zoom);
    end
    checks++;
    if (dbg_state !== ST_BOOT) begin
      errors++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_BOOT);
    end
    rstn = 1'b1;
    hi = 0;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (vif.resend === 1'b1) hi++;
    end
    checks++;
    if (hi !== 16) begin
      errors++;
      $display("FAIL boot_resend_width: got %0d cycles expected 16", hi);
    end
    vif.config_finished = 1'b1;
    n = 0;
    while (vif.busy !== 1'b0 && n < 10) begin
      tick(1);
      n++;
    end
    checks++;
    if (n < 3 || n > 4) begin
      errors++;
      $display("FAIL boot_busy_drop: got %0d cycles expected 3..4", n);
    end
    checks++;
    if (vif.cfg_err !== 1'b0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL boot_done: got cfg_err=%b state=%0d expected cfg_err=0 state=%0d",
               vif.cfg_err, dbg_state, ST_IDLE);
    end
    tick(3);
    vif.config_finished = 1'b0;
    tick(3);
  endtask

  task automatic test_short_press();
    int rr0;
    int n;
    logic [9:0] exp;
    rr0 = resend_rises;
    exp_q.push_back(10'd1);
    for (int g = 0; g < 2; g++) begin
      set_key(1'b0, 1'b0);
      tick(5);
      set_key(1'b0, 1'b1);
      tick(5);
    end
    press(1'b0, 50);
    n = 0;
    while (vif.zoom === 10'd0 && n < 100) begin
      tick(1);
      n++;
    end
    exp = exp_q.pop_front();
    checks++;
    if (vif.zoom !== exp || dbg_state !== ST_CFG_PULSE) begin
      errors++;
      $display("FAIL short_zoom: got zoom=%0d state=%0d expected zoom=%0d state=%0d",
               vif.zoom, dbg_state, exp, ST_CFG_PULSE);
    end
    tick(20);
    pulse_cfg(1'b0);
    tick(2);
    checks++;
    if (vif.busy !== 1'b0 || resend_rises !== rr0 + 1 || vif.zoom !== 10'd1 || drop_cnt !== 0) begin
      errors++;
      $display("FAIL short_done: got busy=%b resends=%0d zoom=%0d drops=%0d expected 0 %0d 1 0",
               vif.busy, resend_rises - rr0, vif.zoom, drop_cnt, 1);
    end
  endtask

  task automatic test_long_to_pattern();
    int rr0;
    int n;
    rr0 = resend_rises;
    press(1'b0, 150);
    n = 0;
    while (vif.wr_halt !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    checks++;
    if (vif.wr_halt !== 1'b1 || dbg_state !== ST_SW_OLD || vif.src_sel !== 1'b0) begin
      errors++;
      $display("FAIL long_start: got halt=%b state=%0d src=%b expected 1 %0d 0",
               vif.wr_halt, dbg_state, vif.src_sel, ST_SW_OLD);
    end
    vif.tp_vs = 1'b1;
    tick(3);
    vif.tp_vs = 1'b0;
    tick(8);
    checks++;
    if (vif.src_sel !== 1'b0 || vif.wr_halt !== 1'b1) begin
      errors++;
      $display("FAIL tp_ignored: got src=%b halt=%b expected src=0 halt=1", vif.src_sel, vif.wr_halt);
    end
    vif.cam_vsync = 1'b1;
    tick(4);
    vif.cam_vsync = 1'b0;
    n = 0;
    while (vif.src_sel !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checks++;
    if (vif.src_sel !== 1'b1 || n !== 3 || vif.wr_halt !== 1'b1 || dbg_state !== ST_SW_NEW) begin
      errors++;
      $display("FAIL cam_edge_switch: got src=%b lat=%0d halt=%b state=%0d expected 1 3 1 %0d",
               vif.src_sel, n, vif.wr_halt, dbg_state, ST_SW_NEW);
    end
    tick(2);
    vif.tp_vs = 1'b1;
    tick(3);
    vif.tp_vs = 1'b0;
    n = 0;
    while (vif.wr_halt !== 1'b0 && n < 10) begin
      tick(1);
      n++;
    end
    checks++;
    if (vif.wr_halt !== 1'b0 || n !== 1 || vif.busy !== 1'b0 || vif.src_sel !== 1'b1 ||
        resend_rises !== rr0 || dbg_state !== ST_IDLE) begin
      errors++;
      $display("FAIL tp_edge_release: got halt=%b lat=%0d busy=%b src=%b resends=%0d state=%0d expected 0 1 0 1 0 %0d",
               vif.wr_halt, n, vif.busy, vif.src_sel, resend_rises - rr0, dbg_state, ST_IDLE);
    end
  endtask

  task automatic test_long_to_camera();
    int rr0;
    int n;
    logic [9:0] exp;
    vif.tp_vs = 1'b1;
    tick(2);
    rr0 = resend_rises;
    press(1'b0, 150);
    n = 0;
    while (vif.wr_halt !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    checks++;
    if (vif.wr_halt !== 1'b1 || dbg_state !== ST_SW_OLD || vif.src_sel !== 1'b1) begin
      errors++;
      $display("FAIL back_start: got halt=%b state=%0d src=%b expected 1 %0d 1",
               vif.wr_halt, dbg_state, vif.src_sel, ST_SW_OLD);
    end
    tick(2);
    vif.tp_vs = 1'b0;
    tick(1);
    vif.tp_vs = 1'b1;
    checks++;
    if (vif.src_sel !== 1'b0) begin
      errors++;
      $display("FAIL back_switch: got src=%b expected 0", vif.src_sel);
    end
    n = 0;
    while (vif.wr_halt !== 1'b0 && n < 70) begin
      tick(1);
      n++;
    end
    checks++;
    if (n !== 50 || vif.resend !== 1'b1 || dbg_state !== ST_CFG_PULSE) begin
      errors++;
      $display("FAIL vs_timeout: got %0d cycles resend=%b state=%0d expected 50 1 %0d",
               n, vif.resend, dbg_state, ST_CFG_PULSE);
    end
    n = 0;
    while (vif.resend === 1'b1 && n < 30) begin
      tick(1);
      n++;
    end
    checks++;
    if (n !== 16) begin
      errors++;
      $display("FAIL back_resend_width: got %0d cycles expected 16", n);
    end
    n = 0;
    while (vif.cfg_err !== 1'b1 && n < 120) begin
      tick(1);
      n++;
    end
    checks++;
    if (n !== 80 || vif.busy !== 1'b0 || dbg_state !== ST_IDLE || resend_rises !== rr0 + 1) begin
      errors++;
      $display("FAIL cfg_timeout: got %0d cycles busy=%b state=%0d resends=%0d expected 80 0 %0d 1",
               n, vif.busy, dbg_state, resend_rises - rr0, ST_IDLE);
    end
    // A later successful configuration leaves the error flag set
    exp_q.push_back(10'd2);
    press(1'b0, 50);
    n = 0;
    while (vif.zoom === 10'd1 && n < 100) begin
      tick(1);
      n++;
    end
    tick(20);
    pulse_cfg(1'b0);
    tick(2);
    exp = exp_q.pop_front();
    checks++;
    if (vif.cfg_err !== 1'b1 || vif.busy !== 1'b0 || vif.zoom !== exp || vif.src_sel !== 1'b0) begin
      errors++;
      $display("FAIL cfg_err_sticky: got err=%b busy=%b zoom=%0d src=%b expected 1 0 %0d 0",
               vif.cfg_err, vif.busy, vif.zoom, vif.src_sel, exp);
    end
  endtask

  task automatic test_zoom_wrap_and_drop();
    int n;
    rstn_w = 1'b1;
    tick(20);
    pulse_cfg(1'b1);
    tick(2);
    checks++;
    if (wif.busy !== 1'b0 || wif.zoom !== 10'd1023 || wif.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap_preload: got busy=%b zoom=%0d err=%b expected 0 1023 0",
               wif.busy, wif.zoom, wif.cfg_err);
    end
    press(1'b1, 50);
    n = 0;
    while (wif.zoom === 10'd1023 && n < 100) begin
      tick(1);
      n++;
    end
    checks++;
    if (wif.zoom !== 10'd0 || dbg_state_w !== ST_CFG_PULSE) begin
      errors++;
      $display("FAIL zoom_wrap: got zoom=%0d state=%0d expected 0 %0d", wif.zoom, dbg_state_w, ST_CFG_PULSE);
    end
    press(1'b1, 30);
    tick(30);
    checks++;
    if (drop_cnt_w !== 1 || wif.zoom !== 10'd0 || dbg_state_w !== ST_CFG_WAIT) begin
      errors++;
      $display("FAIL busy_drop: got drops=%0d zoom=%0d state=%0d expected 1 0 %0d",
               drop_cnt_w, wif.zoom, dbg_state_w, ST_CFG_WAIT);
    end
    pulse_cfg(1'b1);
    tick(2);
    checks++;
    if (wif.busy !== 1'b0 || wif.zoom !== 10'd0 || wif.cfg_err !== 1'b0 || drop_cnt_w !== 1) begin
      errors++;
      $display("FAIL wrap_done: got busy=%b zoom=%0d err=%b drops=%0d expected 0 0 0 1",
               wif.busy, wif.zoom, wif.cfg_err, drop_cnt_w);
    end
  endtask

  task automatic test_reset_mid_switch();
    int n;
    int hi;
    press(1'b0, 150);
    n = 0;
    while (vif.wr_halt !== 1'b1 && n < 60) begin
      tick(1);
      n++;
    end
    checks++;
    if (dbg_state !== ST_SW_OLD || vif.zoom !== 10'd2) begin
      errors++;
      $display("FAIL mid_start: got state=%0d zoom=%0d expected %0d 2", dbg_state, vif.zoom, ST_SW_OLD);
    end
    tick(3);
    rstn = 1'b0;
    #1;
    checks++;
    if ({vif.src_sel, vif.wr_halt, vif.resend, vif.busy, vif.cfg_err} !== 5'b0 ||
        vif.zoom !== 10'd0 || dbg_state !== ST_BOOT) begin
      errors++;
      $display("FAIL async_reset: got flags=%b zoom=%0d state=%0d expected 00000 0 %0d",
               {vif.src_sel, vif.wr_halt, vif.resend, vif.busy, vif.cfg_err}, vif.zoom, dbg_state, ST_BOOT);
    end
    tick(2);
    rstn = 1'b1;
    hi = 0;
    for (int c = 0; c < 22; c++) begin
      tick(1);
      if (vif.resend === 1'b1) hi++;
    end
    checks++;
    if (hi !== 16) begin
      errors++;
      $display("FAIL reboot_resend: got %0d cycles expected 16", hi);
    end
    pulse_cfg(1'b0);
    tick(2);
    checks++;
    if (vif.busy !== 1'b0 || vif.cfg_err !== 1'b0) begin
      errors++;
      $display("FAIL reboot_done: got busy=%b err=%b expected 0 0", vif.busy, vif.cfg_err);
    end
  endtask

  initial begin
    vif.key = 1'b1; vif.cam_vsync = 1'b0; vif.tp_vs = 1'b0; vif.config_finished = 1'b0;
    wif.key = 1'b1; wif.cam_vsync = 1'b0; wif.tp_vs = 1'b0; wif.config_finished = 1'b0;
    test_reset();
    test_short_press();
    test_long_to_pattern();
    test_long_to_camera();
    test_zoom_wrap_and_drop();
    test_reset_mid_switch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog against a stalled run
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before all tests ran");
    $fatal(1, "watchdog");
  end

endmodule
